// File: rtl/gol_ctrl_pkg.sv
// Shared types and constants for the Game of Life run controller.
package gol_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_SET   = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_CLEAR = 2'b11
    } state_e;

    localparam int unsigned ROWS  = 16;
    localparam int unsigned ROW_W = 4;
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

    localparam logic [15:0] OVR_SAT = 16'hFFFF;

endpackage

// File: rtl/gol_btn_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for one raw button.
module gol_btn_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/gol_run_controller.sv
// SET/RUN/PAUSE/CLEAR sequencer with generation timer and step req/done handshake.
// Optional GOL_SINGLE_STEP_EN: an up command in PAUSE requests one generation.
module gol_run_controller
    import gol_ctrl_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = 134217728,
    parameter int unsigned CNT_W       = 28
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_clear,
    input  logic             btn_run,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_load,
    input  logic [1:0]       speed_sel,
    input  logic             step_done,
    output logic             step_req,
    output logic             load_en,
    output logic             clear,
    output logic [ROW_W-1:0] row_sel,
    output logic [1:0]       state_o,
    output logic [15:0]      overrun_cnt
);

    localparam logic [CNT_W:0] BASE = (CNT_W + 1)'(BASE_PERIOD);

    logic [4:0] raw;
    logic [4:0] pulse;

    assign raw = {btn_load, btn_down, btn_up, btn_run, btn_clear};

    for (genvar g = 0; g < 5; g++) begin : g_btn
        gol_btn_edge u_btn (
            .clk     (clk),
            .reset_n (reset_n),
            .btn_i   (raw[g]),
            .pulse_o (pulse[g])
        );
    end

    logic cmd_clr;
    logic cmd_run;
    logic cmd_load;
    logic cmd_up;
    logic cmd_dn;

    // Fixed priority: one winner class per cycle, the rest are dropped.
    always_comb begin
        cmd_clr  = pulse[0];
        cmd_run  = pulse[1] & ~pulse[0];
        cmd_load = pulse[4] & ~pulse[0] & ~pulse[1];
        cmd_up   = pulse[2] & ~pulse[0] & ~pulse[1] & ~pulse[4];
        cmd_dn   = pulse[3] & ~pulse[0] & ~pulse[1] & ~pulse[4];
    end

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             req_q,  req_d;
    logic [15:0]      ovr_q,  ovr_d;
    logic [ROW_W-1:0] row_q;
    logic             load_q;
    logic             clear_q;

    logic [CNT_W:0]   period;
    logic [CNT_W:0]   period_m1;
    logic             tick;
    logic             step_go;

    always_comb begin
        period    = BASE >> {speed_sel, 1'b0};
        period_m1 = (period == '0) ? '0 : period - 1'b1;
        tick      = (state_q == ST_RUN) && ({1'b0, cnt_q} >= period_m1);
    end

    always_comb begin
        step_go = tick;
`ifdef GOL_SINGLE_STEP_EN
        step_go = tick | ((state_q == ST_PAUSE) & cmd_up);
`endif
    end

    always_comb begin
        cnt_d = '0;
        if (state_q == ST_RUN && !tick) begin
            cnt_d = cnt_q + 1'b1;
        end

        req_d = req_q;
        if (req_q && step_done) begin
            req_d = 1'b0;
        end else if (!req_q && step_go) begin
            req_d = 1'b1;
        end

        ovr_d = ovr_q;
        if (tick && req_q && ovr_q != OVR_SAT) begin
            ovr_d = ovr_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_SET;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            ovr_q   <= '0;
            row_q   <= '0;
            load_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ovr_q   <= ovr_d;
            load_q  <= 1'b0;
            clear_q <= 1'b0;
            if (cmd_clr && state_q != ST_CLEAR) begin
                state_q <= ST_CLEAR;
            end else begin
                unique case (state_q)
                    ST_SET: begin
                        if (cmd_run) begin
                            state_q <= ST_RUN;
                        end else if (cmd_load) begin
                            load_q <= 1'b1;
                        end else if (cmd_up && !cmd_dn && row_q != '0) begin
                            row_q <= row_q - 1'b1;
                        end else if (cmd_dn && !cmd_up && row_q != ROW_MAX) begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (cmd_run) begin
                            state_q <= ST_PAUSE;
                        end
                    end
                    ST_PAUSE: begin
                        if (cmd_run) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_CLEAR: begin
                        // Wait out any pending generation, then one clear pulse.
                        if (clear_q) begin
                            state_q <= ST_SET;
                        end else if (!req_q) begin
                            clear_q <= 1'b1;
                            row_q   <= '0;
                            ovr_q   <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign step_req    = req_q;
    assign load_en     = load_q;
    assign clear       = clear_q;
    assign row_sel     = row_q;
    assign state_o     = state_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_gol_run_controller.sv
// Directed scoreboard bench for gol_run_controller with BASE_PERIOD=16.
module tb_gol_run_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        btn_clear = 1'b0;
    logic        btn_run = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_load = 1'b0;
    logic [1:0]  speed_sel = 2'd0;
    logic        step_done;
    logic        step_req;
    logic        load_en;
    logic        clear;
    logic [3:0]  row_sel;
    logic [1:0]  state_o;
    logic [15:0] overrun_cnt;

    logic auto_done = 1'b1;
    logic done_auto = 1'b0;
    logic done_man = 1'b0;
    assign step_done = auto_done ? done_auto : done_man;

    gol_run_controller #(
        .BASE_PERIOD (16),
        .CNT_W       (28)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_clear   (btn_clear),
        .btn_run     (btn_run),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_load    (btn_load),
        .speed_sel   (speed_sel),
        .step_done   (step_done),
        .step_req    (step_req),
        .load_en     (load_en),
        .clear       (clear),
        .row_sel     (row_sel),
        .state_o     (state_o),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    int unsigned exp_rise_q[$];
    logic [3:0]  exp_load_q[$];
    int          rise_cnt = 0;
    int          load_cnt = 0;
    int          clear_cnt = 0;
    bit          saw_run = 1'b0;
    logic        prev_req = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops scoreboard entries as the DUT produces events.
    always @(negedge clk) begin
        done_auto = step_req;
        if (reset_n) begin
            if (step_req && !prev_req) begin
                rise_cnt++;
                if (exp_rise_q.size() > 0) chk("rise_cycle", cyc, exp_rise_q.pop_front());
                else chk("rise_unexpected_qsize", exp_rise_q.size(), 1);
            end
            if (load_en) begin
                load_cnt++;
                if (exp_load_q.size() > 0) chk("load_row", {28'd0, row_sel}, {28'd0, exp_load_q.pop_front()});
                else chk("load_unexpected_qsize", exp_load_q.size(), 1);
            end
            if (clear) clear_cnt++;
            if (state_o == 2'b01) saw_run = 1'b1;
        end
        prev_req = step_req;
    end

    // m = {clear, run, up, down, load}
    task automatic press_start(input logic [4:0] m, output int unsigned t0);
        @(posedge clk);
        #1;
        t0 = cyc;
        {btn_clear, btn_run, btn_up, btn_down, btn_load} = m;
    endtask

    task automatic press_end();
        repeat (2) @(posedge clk);
        #1;
        {btn_clear, btn_run, btn_up, btn_down, btn_load} = 5'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic press(input logic [4:0] m);
        int unsigned t;
        press_start(m, t);
        press_end();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int unsigned t;
        int c0;
        int rc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", {30'd0, state_o}, 32'd0);
        chk("rst_req", {31'd0, step_req}, 32'd0);
        chk("rst_load", {31'd0, load_en}, 32'd0);
        chk("rst_clear", {31'd0, clear}, 32'd0);
        chk("rst_row", {28'd0, row_sel}, 32'd0);
        chk("rst_ovr", {16'd0, overrun_cnt}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // run and clear in the same cycle from SET
        saw_run = 1'b0;
        c0 = clear_cnt;
        press(5'b11000);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rc_state", {30'd0, state_o}, 32'd0);
        chk("rc_never_run", {31'd0, saw_run}, 32'd0);
        chk("rc_clear_pulses", clear_cnt - c0, 32'd1);

        // row cursor and load
        for (int i = 0; i < 3; i++) press(5'b00010);
        @(negedge clk);
        chk("row_down3", {28'd0, row_sel}, 32'd3);
        exp_load_q.push_back(4'd3);
        press(5'b00001);
        @(negedge clk);
        chk("load_pulses", load_cnt, 32'd1);
        for (int i = 0; i < 20; i++) press(5'b00010);
        @(negedge clk);
        chk("row_sat15", {28'd0, row_sel}, 32'd15);
        press(5'b00100);
        @(negedge clk);
        chk("row_up", {28'd0, row_sel}, 32'd14);
        press(5'b00110);
        @(negedge clk);
        chk("row_updown", {28'd0, row_sel}, 32'd14);

        // RUN at speed 0 with prompt done
        speed_sel = 2'd0;
        auto_done = 1'b1;
        rc = rise_cnt;
        press_start(5'b01000, t);
        exp_rise_q.push_back(t + 19);
        exp_rise_q.push_back(t + 35);
        exp_rise_q.push_back(t + 51);
        press_end();
        while (cyc < t + 52) @(posedge clk);
        press(5'b01000);
        @(negedge clk);
        chk("pause_state", {30'd0, state_o}, 32'd2);
        chk("run_rises", rise_cnt - rc, 32'd3);
        chk("run_ovr", {16'd0, overrun_cnt}, 32'd0);
        chk("run_q_empty", exp_rise_q.size(), 32'd0);

        // up in PAUSE
        rc = rise_cnt;
        press_start(5'b00100, t);
`ifdef GOL_SINGLE_STEP_EN
        exp_rise_q.push_back(t + 3);
`endif
        press_end();
        repeat (6) @(posedge clk);
        @(negedge clk);
`ifdef GOL_SINGLE_STEP_EN
        chk("ss_rises", rise_cnt - rc, 32'd1);
`else
        chk("ss_rises", rise_cnt - rc, 32'd0);
`endif
        chk("ss_req_low", {31'd0, step_req}, 32'd0);
        chk("ss_row", {28'd0, row_sel}, 32'd14);
        chk("ss_state", {30'd0, state_o}, 32'd2);

        // RUN at speed 1 with done withheld
        speed_sel = 2'd1;
        done_man = 1'b0;
        auto_done = 1'b0;
        press_start(5'b01000, t);
        exp_rise_q.push_back(t + 7);
        press_end();
        for (int i = 0; i < 20 && !step_req; i++) @(negedge clk);
        chk("ovr_req_rise", {31'd0, step_req}, 32'd1);
        repeat (36) @(posedge clk);
        @(negedge clk);
        chk("ovr_cnt9", {16'd0, overrun_cnt}, 32'd9);
        chk("ovr_req_held", {31'd0, step_req}, 32'd1);

        // clear while a step is pending
        c0 = clear_cnt;
        press(5'b10000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("clr_wait_state", {30'd0, state_o}, 32'd3);
        chk("clr_wait_clear", {31'd0, clear}, 32'd0);
        chk("clr_wait_req", {31'd0, step_req}, 32'd1);
        chk("clr_wait_pulses", clear_cnt - c0, 32'd0);
        @(posedge clk);
        #1 done_man = 1'b1;
        @(posedge clk);
        #1 done_man = 1'b0;
        @(negedge clk);
        chk("clr_req_drop", {31'd0, step_req}, 32'd0);
        chk("clr_still_clear_st", {30'd0, state_o}, 32'd3);
        chk("clr_not_yet", {31'd0, clear}, 32'd0);
        @(negedge clk);
        chk("clr_pulse", {31'd0, clear}, 32'd1);
        chk("clr_ovr_zero", {16'd0, overrun_cnt}, 32'd0);
        chk("clr_row_zero", {28'd0, row_sel}, 32'd0);
        @(negedge clk);
        chk("clr_to_set", {30'd0, state_o}, 32'd0);
        chk("clr_pulse_end", {31'd0, clear}, 32'd0);
        chk("clr_pulses", clear_cnt - c0, 32'd1);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("final_rise_q", exp_rise_q.size(), 32'd0);
        chk("final_load_q", exp_load_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gol_run_controller.md
# gol_run_controller

Sequencing controller for the 16x16 Game of Life datapath. It converts raw board buttons into clean one-cycle commands and runs the SET / RUN / PAUSE / CLEAR mode machine. A programmable generation timer issues step requests to the update engine over a req/done handshake, replacing the free-running `sys_clk[27]` tap so that the datapath can be multi-cycle and clocked from `clk` only.

## Interface
- `BASE_PERIOD`, default 134217728 (2^27): generation period in `clk` cycles at `speed_sel`=0.
- `CNT_W`, default 28: width of the tick counter; must satisfy 2^CNT_W >= BASE_PERIOD.
- `clk`  in  1  system clock; every flop is clocked on its rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `btn_clear`, `btn_run`, `btn_up`, `btn_down`, `btn_load`  in  1 each  raw, asynchronous button levels.
- `speed_sel`  in  2  selects period = BASE_PERIOD >> (2*speed_sel).
- `step_done`  in  1  datapath has finished the requested generation.
- `step_req`  out  1  request for one generation; level signal held until done.
- `load_en`  out  1  one-cycle pulse: write switches into row `row_sel`.
- `clear`  out  1  one-cycle pulse: zero the board and counters.
- `row_sel`  out  4  edit cursor row.
- `state_o`  out  2  SET=00, RUN=01, PAUSE=10, CLEAR=11.
- `overrun_cnt`  out  16  ticks dropped because a step was still pending; saturating.

## Operation
- Each button passes through a 2-flop synchronizer and a rising-edge detector. One press produces one command, however long the button is held.
- Priority of same-cycle commands: clear > run > load > up/down. The lower-priority commands in that cycle are discarded.
- Commands by state:
  - SET: run -> RUN. Load pulses `load_en` for one cycle. Up decrements `row_sel` and down increments it, saturating at 0 and 15. Up and down together leave it unchanged.
  - RUN: run -> PAUSE. Each tick asserts `step_req`.
  - PAUSE: run -> RUN. Load, up and down are ignored.
  - Any state: clear -> CLEAR.
- CLEAR waits while `step_req`=1. Once `step_req`=0, it pulses `clear` for exactly one cycle, sets `row_sel`=0 and `overrun_cnt`=0, then moves to SET on the next edge.
- Tick counter behaviour:
  - Counts only in RUN and is zeroed on every entry to RUN.
  - When count >= period-1, it emits a tick and wraps to 0. The >= compare means that reducing the period mid-count gives an immediate tick.
  - `speed_sel` is sampled every cycle.
- Handshake:
  - `step_req` rises on a tick only while `step_req`=0.
  - It falls on the edge after `step_done` is sampled high.
  - `step_done` is ignored while `step_req`=0.
  - A tick while `step_req`=1 increments `overrun_cnt`, saturating at 16'hFFFF.
- Leaving RUN, by run or by clear, never aborts an outstanding `step_req`.

## Timing
- Reset values: `state_o`=SET, `step_req`=0, `load_en`=0, `clear`=0, `row_sel`=0, `overrun_cnt`=0, tick counter 0, synchronizers 0.
- Button latency: raw high first sampled at edge 0 -> the registered response is visible after edge 2.
- Tick to `step_req`: `step_req` rises after the edge on which count = period-1.
- `step_done` sampled high at edge k -> `step_req` is low after edge k. The earliest next request comes from the next tick.
- Clear with no step pending: `clear` is high for the cycle after entry to CLEAR, and `state_o`=SET on the following edge.
- Asserting `reset_n` low mid-step drops `step_req` immediately. The datapath is expected to share the same reset.

## Configuration
- `GOL_SINGLE_STEP_EN` defined: in PAUSE, an up command asserts `step_req` once if `step_req`=0. If `step_req`=1 the command is dropped and not counted as overrun.
- Undefined: up is ignored in PAUSE, and the logic is not synthesized.

## Structure
- Package `gol_ctrl_pkg`:
  - state encoding constants SET / RUN / PAUSE / CLEAR;
  - row count 16;
  - overrun saturation value.
- Sub-module `gol_btn_edge`: 2-flop synchronizer plus rising-edge detector with async active-low reset; instantiated five times.
- The top level holds the state machine, the tick divider, the handshake and the counters.

## Test plan
All scenarios use BASE_PERIOD=16.
- Reset, then press `btn_down` 3 times and `btn_load` once -> `row_sel`=3 and one `load_en` pulse. Pressing down 20 times saturates `row_sel` at 15.
- `btn_run`, `speed_sel`=0, with `step_done` returned 1 cycle after each request -> `step_req` every 16 cycles and `overrun_cnt`=0.
- RUN with `speed_sel`=1 and `step_done` withheld for 40 cycles -> `step_req` stays high and `overrun_cnt`=9 (ticks every 4 cycles while pending).
- `btn_clear` while `step_req`=1 -> `state_o`=11 and `clear`=0 until `step_done`. Then a single `clear` pulse, SET, and `overrun_cnt`=0.
- `btn_run` and `btn_clear` pressed in the same cycle from SET -> CLEAR wins and the machine never enters RUN.
- With `GOL_SINGLE_STEP_EN`: PAUSE, press `btn_up` -> exactly one `step_req`. Without the macro -> no `step_req` and `row_sel` unchanged.
